bp_stream_host_regs: RTL

Host-side register bank directly downstream of the BP MMIO streaming stage. It consumes the 32-bit outbound MMIO word stream (address beat, then data beat) into a FIFO that the PC host drains through an AXI-lite slave. It also accepts host writes of read-response words into a second FIFO that streams back to the MMIO stage.

---
 rtl/bp_stream_host_pkg.sv | 22 ++
 rtl/bp_stream_host_fifo.sv | 56 +++++
 rtl/bp_stream_host_regs.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bp_stream_host_pkg.sv
// Shared constants and FSM state type for the BP stream host register bank.
package bp_stream_host_pkg;

    localparam logic [7:0] OFF_OUT_COUNT  = 8'h00;
    localparam logic [7:0] OFF_OUT_DATA   = 8'h04;
    localparam logic [7:0] OFF_IN_DATA    = 8'h08;
    localparam logic [7:0] OFF_IN_SPACE   = 8'h0C;
    localparam logic [7:0] OFF_STATUS     = 8'h10;
    localparam logic [7:0] OFF_IRQ_THRESH = 8'h14;

    localparam logic [31:0] UNDERFLOW_WORD = 32'hDEAD_BEEF;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_bresp = 2'd1,
        e_rresp = 2'd2
    } state_e;

endpackage

// File: rtl/bp_stream_host_fifo.sv
// Ready/valid FIFO with occupancy count; els_p must be a power of 2.
module bp_stream_host_fifo #(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         ready_i,
    output logic [$clog2(els_p+1)-1:0]   count_o
);
    localparam int cnt_w_lp = $clog2(els_p+1);
    localparam int ptr_w_lp = $clog2(els_p);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_rd_ptr;
    logic [ptr_w_lp-1:0] r_wr_ptr;
    logic [cnt_w_lp-1:0] r_count;
    logic                w_push;
    logic                w_pop;

    // Ready depends on fullness alone: no pop-to-push bypass when full.
    assign ready_o = (r_count != cnt_w_lp'(els_p));
    assign v_o     = (r_count != '0);
    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;
    assign w_push  = v_i & ready_o;
    assign w_pop   = v_o & ready_i;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ptr_w_lp'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_w_lp'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_w_lp'(1);
                2'b01:   r_count <= r_count - cnt_w_lp'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bp_stream_host_regs.sv
// Host AXI-lite register bank bridging the BP MMIO word streams.
// Optional BP_STREAM_HOST_IRQ_EN adds irq_o and the IRQ_THRESH register.
module bp_stream_host_regs
    import bp_stream_host_pkg::*;
#(
    parameter int s_axil_addr_width_p = 32,
    parameter int s_axil_data_width_p = 32,
    parameter int stream_data_width_p = 32,
    parameter int out_els_p           = 16,
    parameter int in_els_p            = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [s_axil_addr_width_p-1:0] s_axil_awaddr_i,
    input  logic                           s_axil_awvalid_i,
    output logic                           s_axil_awready_o,
    input  logic [s_axil_data_width_p-1:0] s_axil_wdata_i,
    input  logic [3:0]                     s_axil_wstrb_i,
    input  logic                           s_axil_wvalid_i,
    output logic                           s_axil_wready_o,
    output logic [1:0]                     s_axil_bresp_o,
    output logic                           s_axil_bvalid_o,
    input  logic                           s_axil_bready_i,
    input  logic [s_axil_addr_width_p-1:0] s_axil_araddr_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,
    output logic [s_axil_data_width_p-1:0] s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,
    input  logic                           stream_v_i,
    input  logic [stream_data_width_p-1:0] stream_data_i,
    output logic                           stream_ready_o,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_ready_i,
`ifdef BP_STREAM_HOST_IRQ_EN
    output logic                           irq_o,
`endif
    output logic [1:0]                     dbg_state_o
);
    localparam int out_cw_lp = $clog2(out_els_p+1);
    localparam int in_cw_lp  = $clog2(in_els_p+1);

    state_e                         r_state;
    logic                           r_run;
    logic                           r_bvalid;
    logic                           r_rvalid;
    logic [1:0]                     r_bresp;
    logic [1:0]                     r_rresp;
    logic [s_axil_data_width_p-1:0] r_rdata;
    logic [1:0]                     r_status;

    logic [7:0]                     w_waddr;
    logic [7:0]                     w_raddr;
    logic                           w_wr_acc;
    logic                           w_rd_acc;
    logic                           w_wr_map;
    logic                           w_rd_map;
    logic [s_axil_data_width_p-1:0] w_rd_data;
    logic                           w_out_ready;
    logic                           w_out_v;
    logic [stream_data_width_p-1:0] w_out_head;
    logic [out_cw_lp-1:0]           w_out_count;
    logic [s_axil_data_width_p-1:0] w_out_count_ext;
    logic                           w_in_ready;
    logic [in_cw_lp-1:0]            w_in_count;
    logic [in_cw_lp-1:0]            w_in_space;
    logic                           w_pop_out;
    logic                           w_push_in;
    logic [1:0]                     w_set;
    logic [1:0]                     w_clr;
    logic                           w_unused;
`ifdef BP_STREAM_HOST_IRQ_EN
    logic [s_axil_data_width_p-1:0] r_irq_thresh;
    logic                           r_irq;
`endif

    assign w_unused = ^{s_axil_wstrb_i, s_axil_awaddr_i, s_axil_araddr_i};

    assign w_waddr = {s_axil_awaddr_i[7:2], 2'b00};
    assign w_raddr = {s_axil_araddr_i[7:2], 2'b00};

    // r_run holds every ready low until the first clock after reset release.
    assign w_wr_acc = r_run && (r_state == e_idle) && s_axil_awvalid_i && s_axil_wvalid_i;
    assign w_rd_acc = r_run && (r_state == e_idle) && s_axil_arvalid_i &&
                      !(s_axil_awvalid_i && s_axil_wvalid_i);

    assign s_axil_awready_o = w_wr_acc;
    assign s_axil_wready_o  = w_wr_acc;
    assign s_axil_arready_o = w_rd_acc;
    assign s_axil_bvalid_o  = r_bvalid;
    assign s_axil_bresp_o   = r_bresp;
    assign s_axil_rvalid_o  = r_rvalid;
    assign s_axil_rresp_o   = r_rresp;
    assign s_axil_rdata_o   = r_rdata;
    assign stream_ready_o   = r_run & w_out_ready;
    assign dbg_state_o      = r_state;

    assign w_out_count_ext = s_axil_data_width_p'(w_out_count);
    assign w_in_space      = in_cw_lp'(in_els_p) - w_in_count;
    assign w_pop_out       = w_rd_acc && (w_raddr == OFF_OUT_DATA);
    assign w_push_in       = w_wr_acc && (w_waddr == OFF_IN_DATA);

    bp_stream_host_fifo #(.width_p(stream_data_width_p), .els_p(out_els_p)) out_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (stream_v_i & r_run),
        .data_i   (stream_data_i),
        .ready_o  (w_out_ready),
        .v_o      (w_out_v),
        .data_o   (w_out_head),
        .ready_i  (w_pop_out),
        .count_o  (w_out_count)
    );

    bp_stream_host_fifo #(.width_p(stream_data_width_p), .els_p(in_els_p)) in_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (w_push_in),
        .data_i   (s_axil_wdata_i),
        .ready_o  (w_in_ready),
        .v_o      (stream_v_o),
        .data_o   (stream_data_o),
        .ready_i  (stream_ready_i),
        .count_o  (w_in_count)
    );

    always_comb begin
        w_wr_map = 1'b0;
        case (w_waddr)
            OFF_IN_DATA, OFF_STATUS: w_wr_map = 1'b1;
`ifdef BP_STREAM_HOST_IRQ_EN
            OFF_IRQ_THRESH:          w_wr_map = 1'b1;
`endif
            default:                 w_wr_map = 1'b0;
        endcase
    end

    always_comb begin
        w_rd_map  = 1'b1;
        w_rd_data = '0;
        case (w_raddr)
            OFF_OUT_COUNT:  w_rd_data = w_out_count_ext;
            OFF_OUT_DATA:   w_rd_data = w_out_v ? w_out_head : UNDERFLOW_WORD;
            OFF_IN_SPACE:   w_rd_data[in_cw_lp-1:0] = w_in_space;
            OFF_STATUS:     w_rd_data[1:0] = r_status;
`ifdef BP_STREAM_HOST_IRQ_EN
            OFF_IRQ_THRESH: w_rd_data = r_irq_thresh;
`endif
            default:        w_rd_map = 1'b0;
        endcase
    end

    // Sticky set takes precedence over a same-cycle write-1-to-clear.
    assign w_set = {w_push_in & ~w_in_ready, w_pop_out & ~w_out_v};
    assign w_clr = (w_wr_acc && (w_waddr == OFF_STATUS)) ? s_axil_wdata_i[1:0] : 2'b00;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= e_idle;
            r_run    <= 1'b0;
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
            r_status <= 2'b00;
        end else begin
            r_run    <= 1'b1;
            r_status <= (r_status & ~w_clr) | w_set;
            case (r_state)
                e_idle: begin
                    if (w_wr_acc) begin
                        r_state  <= e_bresp;
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_wr_map ? RESP_OKAY : RESP_SLVERR;
                    end else if (w_rd_acc) begin
                        r_state  <= e_rresp;
                        r_rvalid <= 1'b1;
                        r_rresp  <= w_rd_map ? RESP_OKAY : RESP_SLVERR;
                        r_rdata  <= w_rd_data;
                    end
                end
                e_bresp: begin
                    if (s_axil_bready_i) begin
                        r_state  <= e_idle;
                        r_bvalid <= 1'b0;
                    end
                end
                e_rresp: begin
                    if (s_axil_rready_i) begin
                        r_state  <= e_idle;
                        r_rvalid <= 1'b0;
                    end
                end
                default: r_state <= e_idle;
            endcase
        end
    end

`ifdef BP_STREAM_HOST_IRQ_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_irq_thresh <= s_axil_data_width_p'(1);
            r_irq        <= 1'b0;
        end else begin
            if (w_wr_acc && (w_waddr == OFF_IRQ_THRESH)) begin
                r_irq_thresh <= s_axil_wdata_i;
            end
            r_irq <= (w_out_count_ext >= r_irq_thresh) && (r_irq_thresh != '0);
        end
    end

    assign irq_o = r_irq;
`endif

endmodule
